// File: rtl/debug_watch_ctrl_if.sv
// Signal bundle between the debug monitor and the board-level logic around it.
// The master drives controls and channels; the slave returns watch pointers and display.
interface debug_watch_ctrl_if #(
   parameter int DATA_W  = 32,
   parameter int NUM_CH  = 4,
   parameter int REG_NUM = 32,
   parameter int ADDR_W  = 32
);
   localparam int RW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

   logic                     slow_sel;
   logic [1:0]               mode;
   logic                     step_btn;
   logic [NUM_CH-1:0]        ch_sel;
   logic [NUM_CH*DATA_W-1:0] ch_data;
   logic [RW-1:0]            reg_watch_num;
   logic [ADDR_W-1:0]        mem_watch_addr;
   logic [DATA_W-1:0]        disp_data;
   logic                     disp_upd;
   logic                     tick;

   modport master (
      output slow_sel, mode, step_btn, ch_sel, ch_data,
      input  reg_watch_num, mem_watch_addr, disp_data, disp_upd, tick
   );

   modport slave (
      input  slow_sel, mode, step_btn, ch_sel, ch_data,
      output reg_watch_num, mem_watch_addr, disp_data, disp_upd, tick
   );
endinterface

// File: rtl/debug_watch_ctrl.sv
// Debug monitor: paced watch-pointer stepping and registered display channel mux.
// Pacing is a single-cycle enable on clk; no derived clock is generated.
module debug_watch_ctrl #(
   parameter int DATA_W    = 32,
   parameter int NUM_CH    = 4,
   parameter int REG_NUM   = 32,
   parameter int MEM_WORDS = 64,
   parameter int ADDR_W    = 32,
   parameter int ADDR_STEP = 4,
   parameter int DIV_FAST  = 24,
   parameter int DIV_SLOW  = 27,
   parameter int DEB_CYC   = 16
) (
   input logic                clk,
   input logic                reset,
   debug_watch_ctrl_if.slave  bus
);
   localparam int CW    = DIV_SLOW + 1;
   localparam int RW    = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
   localparam int DBW   = $clog2(DEB_CYC + 1);
   localparam logic [RW-1:0]     REG_LAST  = RW'(REG_NUM - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'((MEM_WORDS - 1) * ADDR_STEP);
   localparam logic [ADDR_W-1:0] ADDR_INC  = ADDR_W'(ADDR_STEP);
   localparam logic [DBW-1:0]    DEB_LAST  = DBW'(DEB_CYC - 1);

   logic [CW-1:0]     div_cnt;
   logic              fast_hit;
   logic              slow_hit;
   logic              tick_raw;
   logic              sync1;
   logic              sync2;
   logic              deb;
   logic              deb_q;
   logic [DBW-1:0]    deb_cnt;
   logic              step_pulse;
   logic              is_auto;
   logic              is_manual;
   logic              adv;
   logic              one_hot;
   logic [DATA_W-1:0] sel_word;
   logic [RW-1:0]     reg_num;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] disp;
   logic              upd;

   // Free-running divider; the tick is decoded from its low bits.
   always_ff @(posedge clk) begin
      if (reset) div_cnt <= '0;
      else       div_cnt <= div_cnt + 1'b1;
   end

   // Tick decode: bit D set with all lower bits clear; reset masks it.
   always_comb begin
      fast_hit = div_cnt[DIV_FAST] && (div_cnt[DIV_FAST-1:0] == '0);
      slow_hit = div_cnt[DIV_SLOW] && (div_cnt[DIV_SLOW-1:0] == '0);
      tick_raw = (bus.slow_sel ? slow_hit : fast_hit) && !reset;
   end

   // Synchronise the button, then accept a level only after DEB_CYC stable cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         deb     <= 1'b0;
         deb_q   <= 1'b0;
         deb_cnt <= '0;
      end else begin
         sync1 <= bus.step_btn;
         sync2 <= sync1;
         deb_q <= deb;
         if (sync2 != deb) begin
            if (deb_cnt == DEB_LAST) begin
               deb     <= sync2;
               deb_cnt <= '0;
            end else begin
               deb_cnt <= deb_cnt + 1'b1;
            end
         end else begin
            deb_cnt <= '0;
         end
      end
   end

   // Advance source depends on mode; HOLD drops everything.
   always_comb begin
      step_pulse = deb && !deb_q;
      is_auto    = (bus.mode == 2'b00);
      is_manual  = (bus.mode == 2'b01);
      adv        = (is_auto && tick_raw) || (is_manual && step_pulse);
   end

   // Channel mux; zero or multi-hot select yields zero.
   always_comb begin
      sel_word = '0;
      one_hot  = (bus.ch_sel != '0) &&
                 ((bus.ch_sel & (bus.ch_sel - 1'b1)) == '0);
      for (int k = 0; k < NUM_CH; k++) begin
         if (bus.ch_sel[k]) sel_word = sel_word | bus.ch_data[k*DATA_W +: DATA_W];
      end
      if (!one_hot) sel_word = '0;
   end

   // Watch pointers step on each advance; disp_upd marks the new values.
   always_ff @(posedge clk) begin
      if (reset) begin
         reg_num  <= '0;
         mem_addr <= '0;
         upd      <= 1'b0;
      end else begin
         upd <= adv;
         if (adv) begin
            reg_num  <= (reg_num == REG_LAST) ? '0 : reg_num + 1'b1;
            mem_addr <= (mem_addr == ADDR_LAST) ? '0 : mem_addr + ADDR_INC;
         end
      end
   end

   // Display register follows the selected channel except while frozen in HOLD.
   always_ff @(posedge clk) begin
      if (reset)                    disp <= '0;
      else if (is_auto || is_manual) disp <= sel_word;
   end

   assign bus.tick           = tick_raw;
   assign bus.reg_watch_num  = reg_num;
   assign bus.mem_watch_addr = mem_addr;
   assign bus.disp_data      = disp;
   assign bus.disp_upd       = upd;
endmodule

// File: tb/tb_debug_watch_ctrl.sv
// Bench for debug_watch_ctrl: directed phases with random channel traffic,
// checked every cycle against a cycle-count/advance-count reference model.
module tb_debug_watch_ctrl;
   localparam int DATA_W    = 32;
   localparam int NUM_CH    = 4;
   localparam int REG_NUM   = 4;
   localparam int MEM_WORDS = 3;
   localparam int ADDR_W    = 32;
   localparam int ADDR_STEP = 4;
   localparam int DIV_FAST  = 3;
   localparam int DIV_SLOW  = 5;
   localparam int DEB_CYC   = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;

   debug_watch_ctrl_if #(
      .DATA_W(DATA_W), .NUM_CH(NUM_CH), .REG_NUM(REG_NUM), .ADDR_W(ADDR_W)
   ) bus ();

   debug_watch_ctrl #(
      .DATA_W(DATA_W), .NUM_CH(NUM_CH), .REG_NUM(REG_NUM),
      .MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W), .ADDR_STEP(ADDR_STEP),
      .DIV_FAST(DIV_FAST), .DIV_SLOW(DIV_SLOW), .DEB_CYC(DEB_CYC)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n = 0;
   int k = 0;
   int cyc = 0;
   int man_at = -1;
   logic [31:0] dd = '0;
   logic upd = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic tick_exp();
      int d;
      d = bus.slow_sel ? DIV_SLOW : DIV_FAST;
      return !reset && ((n % (1 << (d + 1))) == (1 << d));
   endfunction

   function automatic logic [31:0] sel_model();
      if ($countones(bus.ch_sel) != 1) return '0;
      for (int i = 0; i < NUM_CH; i++)
         if (bus.ch_sel[i]) return bus.ch_data[i*DATA_W +: DATA_W];
      return '0;
   endfunction

   task automatic cycle();
      logic t_pre;
      logic adv;
      logic [31:0] nxt;
      t_pre = tick_exp();
      nxt = sel_model();
      @(posedge clk);
      cyc++;
      adv = !reset && ((bus.mode == 2'b00 && t_pre) ||
                       (bus.mode == 2'b01 && cyc == man_at));
      if (reset) begin
         n = 0; k = 0; dd = '0; upd = 1'b0;
      end else begin
         n = (n + 1) % (1 << (DIV_SLOW + 1));
         if (adv) k++;
         upd = adv;
         if (bus.mode < 2'd2) dd = nxt;
      end
      #1;
      chk("tick", 32'(bus.tick), 32'(tick_exp()));
      chk("reg", 32'(bus.reg_watch_num), 32'(k % REG_NUM));
      chk("addr", bus.mem_watch_addr, 32'((k % MEM_WORDS) * ADDR_STEP));
      chk("disp", bus.disp_data, dd);
      chk("upd", 32'(bus.disp_upd), 32'(upd));
   endtask

   task automatic rand_data();
      bus.ch_data = {$urandom, $urandom, $urandom, $urandom};
   endtask

   initial begin
      int kk;
      logic [31:0] held;
      bus.slow_sel = 1'b0;
      bus.mode     = 2'b00;
      bus.step_btn = 1'b0;
      bus.ch_sel   = '0;
      bus.ch_data  = '0;
      repeat (3) cycle();
      chk("rst_disp", bus.disp_data, 32'h0);
      chk("rst_reg", 32'(bus.reg_watch_num), 32'h0);

      // 1: fast ticks at 8, 24, 40
      reset = 1'b0;
      for (int i = 1; i <= 41; i++) begin
         cycle();
         if (i == 8 || i == 24 || i == 40) chk("t1_tick", 32'(bus.tick), 32'h1);
      end
      chk("t1_reg", 32'(bus.reg_watch_num), 32'd3);
      chk("t1_addr", bus.mem_watch_addr, 32'd0);

      // 2: slow ticks with random traffic
      bus.slow_sel = 1'b1;
      for (int i = 0; i < 140; i++) begin
         rand_data();
         bus.ch_sel = 4'(1 << $urandom_range(0, 3));
         cycle();
      end

      // 3: manual stepping with debounce
      bus.mode = 2'b01;
      repeat (20) cycle();
      kk = k;
      bus.step_btn = 1'b1;
      repeat (2) cycle();
      bus.step_btn = 1'b0;
      repeat (12) cycle();
      chk("t3_glitch", 32'(bus.reg_watch_num), 32'(kk % REG_NUM));
      bus.step_btn = 1'b1;
      man_at = cyc + 7;
      repeat (10) cycle();
      bus.step_btn = 1'b0;
      repeat (16) cycle();
      chk("t3_press", 32'(bus.reg_watch_num), 32'((kk + 1) % REG_NUM));

      // 4: channel select
      rand_data();
      bus.ch_data[2*DATA_W +: DATA_W] = 32'hDEADBEEF;
      bus.ch_sel = 4'b0100;
      cycle();
      chk("t4_sel", bus.disp_data, 32'hDEADBEEF);
      bus.ch_sel = 4'b0110;
      cycle();
      chk("t4_multi", bus.disp_data, 32'h0);

      // 5: hold freezes display and pointers
      bus.mode = 2'b00;
      bus.ch_sel = 4'b0001;
      rand_data();
      cycle();
      held = bus.ch_data[31:0];
      kk = k;
      bus.mode = 2'b10;
      for (int i = 0; i < 100; i++) begin
         rand_data();
         cycle();
      end
      chk("t5_disp", bus.disp_data, held);
      chk("t5_reg", 32'(bus.reg_watch_num), 32'(kk % REG_NUM));
      bus.mode = 2'b00;
      rand_data();
      held = bus.ch_data[31:0];
      cycle();
      chk("t5_resume", bus.disp_data, held);

      // random mixed phase
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 15) == 0) bus.mode = 2'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(2, 3));
         if ($urandom_range(0, 31) == 0) bus.slow_sel = 1'($urandom);
         bus.ch_sel = 4'($urandom);
         rand_data();
         cycle();
      end

      // 6: reset during tick cycle
      bus.mode = 2'b00;
      bus.slow_sel = 1'b0;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      repeat (8) cycle();
      chk("t6_pre", 32'(bus.tick), 32'h1);
      reset = 1'b1;
      #1;
      chk("t6_mask", 32'(bus.tick), 32'h0);
      cycle();
      chk("t6_reg", 32'(bus.reg_watch_num), 32'h0);
      reset = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         cycle();
         if (i == 8) chk("t6_first", 32'(bus.tick), 32'h1);
      end
      chk("t6_adv", 32'(bus.reg_watch_num), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
